cam_pwr_seq: RTL and testbench
==============================

Name: cam_pwr_seq

Overview:
- Power-up and configuration sequencer for the OV5640 camera.
- Runs on the 24 MHz camera clock produced by the camera PLL; the same clock drives the sensor XCLK.
- Drives the sensor PWDN and RESETB pins with datasheet timing, then hands off to the SCCB register loader through a start/done handshake.
- Retries on configuration failure or timeout; reports ready/fail to the capture path.

Parameters:
- T_PWDN_CYC, 24000: cycles PWDN held high after reset release (1 ms at 24 MHz).
- T_RST_CYC, 24000: cycles RESETB held low after PWDN falls (1 ms).
- T_SETTLE_CYC, 480000: cycles after RESETB rises before the first SCCB access (20 ms).
- CFG_TIMEOUT_CYC, 2400000: maximum cycles to wait for cfg_done (100 ms).
- MAX_RETRY, 3: configuration attempts before declaring failure.

Ports:
- clk  in  1  24 MHz camera clock (PLL clkout0).
- rst_n  in  1  asynchronous active-low reset; tie to the PLL-lock-qualified system reset.
- cam_pwdn  out  1  sensor power-down pin, active high.
- cam_rst_n  out  1  sensor reset pin, active low.
- cfg_start  out  1  single-cycle pulse that starts the SCCB register table load.
- cfg_done  in  1  single-cycle pulse from the loader: table complete.
- cfg_err  in  1  single-cycle pulse from the loader: NACK or bus error.
- cam_ready  out  1  high while the sensor is configured; enables the capture path.
- cam_fail  out  1  high after MAX_RETRY failed attempts.
- retry_cnt  out  2  number of failed attempts so far; width is $clog2(MAX_RETRY+1).

Behaviour:
- Reset values (async, rst_n low):
  - cam_pwdn=1, cam_rst_n=0, cfg_start=0, cam_ready=0, cam_fail=0, retry_cnt=0.
  - State = S_PWDN, counter = 0.
- Counter:
  - Single down-counter, width $clog2 of the largest cycle parameter.
  - Loaded with N-1 on state entry; the state exits the cycle the counter reads 0, so each state dwells exactly N cycles.
- States (all outputs registered):
  - S_PWDN: pwdn=1, rst_n=0. After T_PWDN_CYC -> S_RST.
  - S_RST: pwdn=0, rst_n=0. After T_RST_CYC -> S_SETTLE.
  - S_SETTLE: pwdn=0, rst_n=1. After T_SETTLE_CYC -> S_CFG_START.
  - S_CFG_START: cfg_start=1 for exactly one cycle; load the counter with CFG_TIMEOUT_CYC-1 -> S_CFG_WAIT.
  - S_CFG_WAIT:
    - cfg_done -> S_READY.
    - cfg_err or counter==0 -> retry_cnt+1. If the new value equals MAX_RETRY -> S_FAIL; otherwise -> S_PWDN for a full power cycle.
  - S_READY: cam_ready=1; terminal until reset.
  - S_FAIL: cam_fail=1, cam_pwdn=1, cam_rst_n=0; terminal until reset.
- Simultaneous cfg_done and cfg_err in one cycle: cfg_err wins (treated as failure).
- cfg_done/cfg_err outside S_CFG_WAIT: ignored.
- retry_cnt saturates at MAX_RETRY and clears only on reset.
- Reset asserted mid-sequence: immediate return to reset values; the sensor is power-cycled again.
- Latency: reset release to cfg_start high = T_PWDN_CYC+T_RST_CYC+T_SETTLE_CYC cycles, ±1.
- cam_ready rises on the cycle after cfg_done is sampled.

Optional Feature:
- Macro: CAM_PWR_SEQ_RESTART_EN.
- When defined:
  - Adds input restart_req (1 bit, level sampled each cycle).
  - In S_READY or S_FAIL, restart_req=1 -> S_PWDN with retry_cnt cleared; cam_ready and cam_fail drop on the next cycle.
  - In all other states restart_req is ignored.
- When undefined: the port is absent and S_READY/S_FAIL are terminal until rst_n.

Decomposition:
- Shared package cam_pkg holds:
  - the state enum (S_PWDN, S_RST, S_SETTLE, S_CFG_START, S_CFG_WAIT, S_READY, S_FAIL);
  - default timing constants for 24 MHz;
  - the 3'b width constant for the state register.
- One sub-module, cam_seq_timer: loadable down-counter with load/value/zero outputs, parameterised width.
- The FSM and output registers stay in cam_pwr_seq.

Test Plan (bench overrides T_PWDN_CYC=10, T_RST_CYC=10, T_SETTLE_CYC=20, CFG_TIMEOUT_CYC=50, MAX_RETRY=3):
- Nominal: release rst_n, reply with cfg_done 5 cycles after cfg_start.
  - cam_pwdn falls at cycle 10, cam_rst_n rises at cycle 20, cfg_start pulses once at cycle 40.
  - cam_ready=1 at cycle 47; retry_cnt=0.
- Single error: cfg_err on the first attempt, cfg_done on the second.
  - Full PWDN/RST/SETTLE replay; second cfg_start at about cycle 82.
  - cam_ready=1; retry_cnt=1.
- Timeout: never answer.
  - Three attempts, each ending 50 cycles after cfg_start.
  - cam_fail=1, retry_cnt=3, cam_pwdn=1, cam_rst_n=0, cam_ready=0.
- Collision: cfg_done and cfg_err asserted in the same cycle.
  - Treated as an error; retry_cnt=1; no cam_ready.
- Stray and mid-sequence reset:
  - cfg_done pulsed during S_SETTLE is ignored; cam_ready stays 0.
  - rst_n pulsed low at cycle 15 restores all reset values asynchronously; the sequence restarts from 0.
- With CAM_PWR_SEQ_RESTART_EN defined:
  - restart_req in S_FAIL clears retry_cnt and cam_fail, and the sequence reruns to cam_ready.
  - restart_req during S_SETTLE has no effect.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV5640 power-up/configuration sequencer.
package cam_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PWDN      = 3'd0,
        S_RST       = 3'd1,
        S_SETTLE    = 3'd2,
        S_CFG_START = 3'd3,
        S_CFG_WAIT  = 3'd4,
        S_READY     = 3'd5,
        S_FAIL      = 3'd6
    } cam_state_e;

    // Default timing for a 24 MHz sensor clock
    localparam int unsigned DEF_T_PWDN_CYC      = 24000;
    localparam int unsigned DEF_T_RST_CYC       = 24000;
    localparam int unsigned DEF_T_SETTLE_CYC    = 480000;
    localparam int unsigned DEF_CFG_TIMEOUT_CYC = 2400000;
    localparam int unsigned DEF_MAX_RETRY       = 3;

    // Larger of two unsigned values, used to size the shared counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_seq_timer.sv
// Loadable down-counter that stops at zero; zero_o is registered alongside the count.
module cam_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q;
    logic         zero_q;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            zero_q  <= 1'b1;
        end else if (load_i) begin
            value_q <= load_val_i;
            zero_q  <= (load_val_i == '0);
        end else if (value_q != '0) begin
            value_q <= value_q - W'(1);
            zero_q  <= (value_q == W'(1));
        end
    end

    assign value_o = value_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/cam_pwr_seq.sv
// OV5640 power-up sequencer: PWDN/RESETB timing, SCCB load handshake, retry and fail.
// Optional restart from READY/FAIL via restart_req when CAM_PWR_SEQ_RESTART_EN is defined.
module cam_pwr_seq
    import cam_pkg::*;
#(
    parameter int unsigned T_PWDN_CYC      = DEF_T_PWDN_CYC,
    parameter int unsigned T_RST_CYC       = DEF_T_RST_CYC,
    parameter int unsigned T_SETTLE_CYC    = DEF_T_SETTLE_CYC,
    parameter int unsigned CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
    localparam int unsigned RETRY_W        = $clog2(MAX_RETRY + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CAM_PWR_SEQ_RESTART_EN
    input  logic               restart_req,
`endif
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               cfg_start,
    input  logic               cfg_done,
    input  logic               cfg_err,
    output logic               cam_ready,
    output logic               cam_fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned MAX_CYC = max_u(max_u(T_PWDN_CYC, T_RST_CYC),
                                            max_u(T_SETTLE_CYC, CFG_TIMEOUT_CYC));
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]   LD_PWDN    = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0]   LD_RST     = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   LD_SETTLE  = CNT_W'(T_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   LD_TIMEOUT = CNT_W'(CFG_TIMEOUT_CYC - 1);
    // After reset the counter starts at zero, so the first load happens one cycle into S_PWDN
    localparam logic [CNT_W-1:0]   LD_PWDN_FIRST = CNT_W'((T_PWDN_CYC > 1) ? (T_PWDN_CYC - 2) : 0);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    cam_state_e         state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               armed_q, armed_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic [CNT_W-1:0]   tmr_value;
    logic               tmr_zero;

    logic pwdn_q, pwdn_d;
    logic rstn_q, rstn_d;
    logic start_q, start_d;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    cam_seq_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .value_o   (tmr_value),
        .zero_o    (tmr_zero)
    );

    // Saturating failure count
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : (retry_q + RETRY_W'(1));

    // State register and sequencing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWDN;
            retry_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            armed_q <= armed_d;
        end
    end

    // Next-state, retry accounting and counter reload on state entry
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        armed_d      = 1'b1;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            S_PWDN: begin
                if (!armed_q) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_PWDN_FIRST;
                end else if (tmr_zero) begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                if (tmr_zero) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (tmr_zero) state_d = S_CFG_START;
            end
            S_CFG_START: begin
                state_d = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                // An error beats a simultaneous done; a done in the last window still counts
                if (cfg_err || (!cfg_done && (tmr_value == '0))) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_PWDN;
                end else if (cfg_done) begin
                    state_d = S_READY;
                end
            end
            S_READY, S_FAIL: begin
`ifdef CAM_PWR_SEQ_RESTART_EN
                if (restart_req) begin
                    state_d = S_PWDN;
                    retry_d = '0;
                end
`endif
            end
            default: state_d = S_PWDN;
        endcase

        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                S_PWDN:     tmr_load_val = LD_PWDN;
                S_RST:      tmr_load_val = LD_RST;
                S_SETTLE:   tmr_load_val = LD_SETTLE;
                S_CFG_WAIT: tmr_load_val = LD_TIMEOUT;
                default:    tmr_load_val = '0;
            endcase
        end
    end

    // Pin and status values for the state being entered
    always_comb begin
        pwdn_d  = (state_d == S_PWDN) || (state_d == S_FAIL);
        rstn_d  = !((state_d == S_PWDN) || (state_d == S_RST) || (state_d == S_FAIL));
        start_d = (state_d == S_CFG_START);
        ready_d = (state_d == S_READY);
        fail_d  = (state_d == S_FAIL);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwdn_q  <= 1'b1;
            rstn_q  <= 1'b0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            pwdn_q  <= pwdn_d;
            rstn_q  <= rstn_d;
            start_q <= start_d;
            ready_q <= ready_d;
            fail_q  <= fail_d;
        end
    end

    assign cam_pwdn  = pwdn_q;
    assign cam_rst_n = rstn_q;
    assign cfg_start = start_q;
    assign cam_ready = ready_q;
    assign cam_fail  = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with shortened timing (10/10/20/50, 3 attempts).
// Cycle n below means "after the n-th rising edge following reset release".
module tb_cam_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       cfg_done;
    logic       cfg_err;
    logic       restart_req;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       cfg_start;
    logic       cam_ready;
    logic       cam_fail;
    logic [1:0] retry_cnt;

    int checks;
    int failures;
    int c;
    int starts;
    int last_start;

    cam_pwr_seq #(
        .T_PWDN_CYC     (10),
        .T_RST_CYC      (10),
        .T_SETTLE_CYC   (20),
        .CFG_TIMEOUT_CYC(50),
        .MAX_RETRY      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CAM_PWR_SEQ_RESTART_EN
        .restart_req(restart_req),
`endif
        .cam_pwdn   (cam_pwdn),
        .cam_rst_n  (cam_rst_n),
        .cfg_start  (cfg_start),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cam_ready  (cam_ready),
        .cam_fail   (cam_fail),
        .retry_cnt  (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        c++;
        @(negedge clk);
        if (cfg_start === 1'b1) begin
            starts++;
            last_start = c;
        end
    endtask

    task automatic run_to(input int target);
        while (c < target) tick();
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        cfg_done    = 1'b0;
        cfg_err     = 1'b0;
        restart_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        c          = 0;
        starts     = 0;
        last_start = -1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        c           = 0;
        starts      = 0;
        last_start  = -1;
        rst_n       = 1'b0;
        cfg_done    = 1'b0;
        cfg_err     = 1'b0;
        restart_req = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pwdn",  cam_pwdn,  1);
        chk("rst_rstn",  cam_rst_n, 0);
        chk("rst_start", cfg_start, 0);
        chk("rst_ready", cam_ready, 0);
        chk("rst_fail",  cam_fail,  0);
        chk("rst_retry", retry_cnt, 0);

        // Nominal power-up, loader answers done
        apply_reset();
        run_to(9);  chk("nom_pwdn_c9",   cam_pwdn,  1);
        run_to(10); chk("nom_pwdn_c10",  cam_pwdn,  0);
                    chk("nom_rstn_c10",  cam_rst_n, 0);
        run_to(19); chk("nom_rstn_c19",  cam_rst_n, 0);
        run_to(20); chk("nom_rstn_c20",  cam_rst_n, 1);
        run_to(39); chk("nom_start_c39", cfg_start, 0);
        run_to(40); chk("nom_start_c40", cfg_start, 1);
        run_to(41); chk("nom_start_c41", cfg_start, 0);
        run_to(46); chk("nom_ready_c46", cam_ready, 0);
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        chk("nom_ready_c47", cam_ready, 1);
        chk("nom_retry",     retry_cnt, 0);
        run_to(60);
        chk("nom_ready_hold", cam_ready, 1);
        chk("nom_starts",     starts,    1);

        // Error on first attempt, done on the second
        apply_reset();
        run_to(41);
        cfg_err = 1'b1; tick(); cfg_err = 1'b0;
        chk("err_retry_c42", retry_cnt, 1);
        chk("err_pwdn_c42",  cam_pwdn,  1);
        chk("err_rstn_c42",  cam_rst_n, 0);
        run_to(81); chk("err_start_c81", cfg_start, 0);
        run_to(82); chk("err_start_c82", cfg_start, 1);
        run_to(88);
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        chk("err_ready", cam_ready, 1);
        chk("err_retry", retry_cnt, 1);
        chk("err_fail",  cam_fail,  0);

        // Loader never answers: three timeouts, then fail
        apply_reset();
        run_to(90);  chk("to_retry_c90",  retry_cnt, 0);
        run_to(91);  chk("to_retry_c91",  retry_cnt, 1);
                     chk("to_pwdn_c91",   cam_pwdn,  1);
        run_to(131); chk("to_start2_at",  last_start, 131);
        run_to(222); chk("to_start3_at",  last_start, 222);
                     chk("to_starts3",    starts,     3);
        run_to(272); chk("to_fail_c272",  cam_fail,  0);
                     chk("to_retry_c272", retry_cnt, 2);
        run_to(273); chk("to_fail_c273",  cam_fail,  1);
                     chk("to_retry_c273", retry_cnt, 3);
                     chk("to_pwdn_fail",  cam_pwdn,  1);
                     chk("to_rstn_fail",  cam_rst_n, 0);
                     chk("to_ready_fail", cam_ready, 0);
        run_to(280);
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        run_to(300);
        chk("to_fail_hold",  cam_fail,  1);
        chk("to_ready_hold", cam_ready, 0);
        chk("to_retry_hold", retry_cnt, 3);
        chk("to_starts_end", starts,    3);
`ifdef CAM_PWR_SEQ_RESTART_EN
        // Restart out of FAIL reruns the full sequence
        restart_req = 1'b1; tick(); restart_req = 1'b0;
        chk("rs_fail_c301",  cam_fail,  0);
        chk("rs_retry_c301", retry_cnt, 0);
        chk("rs_pwdn_c301",  cam_pwdn,  1);
        run_to(341); chk("rs_start_at", last_start, 341);
        run_to(347);
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        chk("rs_ready", cam_ready, 1);
        chk("rs_retry", retry_cnt, 0);
`endif

        // done and err in the same cycle count as an error
        apply_reset();
        run_to(41);
        cfg_done = 1'b1; cfg_err = 1'b1; tick(); cfg_done = 1'b0; cfg_err = 1'b0;
        chk("col_retry", retry_cnt, 1);
        chk("col_ready", cam_ready, 0);
        chk("col_pwdn",  cam_pwdn,  1);
        run_to(60);
        chk("col_ready_hold", cam_ready, 0);

        // Mid-sequence asynchronous reset, then a stray done during settle
        apply_reset();
        run_to(15); chk("mid_pwdn_c15", cam_pwdn, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_pwdn_async", cam_pwdn,  1);
        chk("mid_rstn_async", cam_rst_n, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        c          = 0;
        starts     = 0;
        last_start = -1;
        run_to(9);  chk("mid_pwdn_c9",  cam_pwdn, 1);
        run_to(10); chk("mid_pwdn_c10", cam_pwdn, 0);
        run_to(25);
        cfg_done    = 1'b1;
        restart_req = 1'b1;
        tick();
        cfg_done    = 1'b0;
        restart_req = 1'b0;
        chk("stray_ready_c26", cam_ready, 0);
        run_to(40); chk("stray_start_c40", cfg_start, 1);
                    chk("stray_starts",    starts,    1);
        run_to(45); chk("stray_ready_c45", cam_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
